// File: rtl/baccarat_dealer_ctrl.sv
// Baccarat dealer sequencing controller.
// Issues the card-register load strobes in deal order, applies the player and
// banker third-card rules to the datapath totals, latches the hand result and
// keeps saturating hand statistics.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_P1    | wait for step, load player card 1
// S_D1    | wait for step, load banker card 1
// S_P2    | wait for step, load player card 2
// S_D2    | wait for step, load banker card 2
// S_EVAL1 | automatic: natural / player draw / banker draw decision
// S_P3    | wait for step, load player third card
// S_EVAL2 | automatic: banker rule using player third card value
// S_D3    | wait for step, load banker third card
// S_SCORE | automatic: register result, bump statistics
// S_DONE  | hold result; step clears cards and starts the next hand
module baccarat_dealer_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             step,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             clr_cards,
  output logic             done,
  output logic             player_win,
  output logic             dealer_win,
  output logic             tie,
  output logic [CNT_W-1:0] hands,
  output logic [CNT_W-1:0] pwins,
  output logic [CNT_W-1:0] dwins,
  output logic [CNT_W-1:0] ties
);

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_SCORE, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] third_val;
  logic       bank_draw;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Face cards and tens count as zero; code 0 (empty) also yields zero.
  always_comb begin
    third_val = 4'd0;
    if (pcard3 >= 4'd1 && pcard3 <= 4'd9) third_val = pcard3;
  end

  // Banker draw decision after the player has taken a third card.
  always_comb begin
    bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (third_val != 4'd8);
      4'd4:             bank_draw = (third_val >= 4'd2) && (third_val <= 4'd7);
      4'd5:             bank_draw = (third_val >= 4'd4) && (third_val <= 4'd7);
      4'd6:             bank_draw = (third_val >= 4'd6) && (third_val <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  // Next-state and Mealy strobe logic; strobes are suppressed during reset.
  always_comb begin
    state_nxt   = state;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    clr_cards   = 1'b0;
    case (state)
      S_P1: if (step) begin load_pcard1 = 1'b1; state_nxt = S_D1; end
      S_D1: if (step) begin load_dcard1 = 1'b1; state_nxt = S_P2; end
      S_P2: if (step) begin load_pcard2 = 1'b1; state_nxt = S_D2; end
      S_D2: if (step) begin load_dcard2 = 1'b1; state_nxt = S_EVAL1; end
      S_EVAL1: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_nxt = S_SCORE;
        else if (pscore <= 4'd5)             state_nxt = S_P3;
        else if (dscore <= 4'd5)             state_nxt = S_D3;
        else                                 state_nxt = S_SCORE;
      end
      S_P3: if (step) begin load_pcard3 = 1'b1; state_nxt = S_EVAL2; end
      S_EVAL2: state_nxt = bank_draw ? S_D3 : S_SCORE;
      S_D3: if (step) begin load_dcard3 = 1'b1; state_nxt = S_SCORE; end
      S_SCORE: state_nxt = S_DONE;
      S_DONE: if (step) begin clr_cards = 1'b1; state_nxt = S_P1; end
      default: state_nxt = S_P1;
    endcase
    if (!resetb) begin
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      clr_cards   = 1'b0;
    end
  end

  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetb) state <= S_P1;
    else         state <= state_nxt;
  end

  // Result flags: set once in S_SCORE, cleared when the next hand starts.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      tie        <= 1'b0;
    end else if (state == S_SCORE) begin
      player_win <= (pscore > dscore);
      dealer_win <= (dscore > pscore);
      tie        <= (pscore == dscore);
    end else if (state == S_DONE && step) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      tie        <= 1'b0;
    end
  end

  // Saturating statistics, persistent across hands until reset.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      hands <= '0;
      pwins <= '0;
      dwins <= '0;
      ties  <= '0;
    end else if (state == S_SCORE) begin
      hands <= sat_inc(hands);
      if (pscore > dscore)      pwins <= sat_inc(pwins);
      else if (dscore > pscore) dwins <= sat_inc(dwins);
      else                      ties  <= sat_inc(ties);
    end
  end

endmodule

// File: tb/tb_baccarat_dealer_ctrl.sv
// Self-checking bench for baccarat_dealer_ctrl: directed and random hands
// against a rule-level model of the game; a second instance with 2-bit
// counters exercises saturation.
module tb_baccarat_dealer_ctrl;

  logic       clk = 1'b0;
  logic       resetb;
  logic       step;
  logic [3:0] pscore, dscore, pcard3;

  logic       lp1, lp2, lp3, ld1, ld2, ld3, clr, done, pw, dw, tw;
  logic [7:0] hands, pwins, dwins, ties;
  logic       s_lp1, s_lp2, s_lp3, s_ld1, s_ld2, s_ld3, s_clr, s_done, s_pw, s_dw, s_tw;
  logic [1:0] s_hands, s_pwins, s_dwins, s_ties;

  int checks = 0;
  int errors = 0;
  int hm = 0, pm = 0, dm = 0, tm = 0;

  localparam logic [6:0] L_NONE = 7'b0000000;
  localparam logic [6:0] L_P1   = 7'b1000000;
  localparam logic [6:0] L_D1   = 7'b0100000;
  localparam logic [6:0] L_P2   = 7'b0010000;
  localparam logic [6:0] L_D2   = 7'b0001000;
  localparam logic [6:0] L_P3   = 7'b0000100;
  localparam logic [6:0] L_D3   = 7'b0000010;
  localparam logic [6:0] L_CLR  = 7'b0000001;

  // Banker draws when bit v (player third-card value) is set, indexed by banker total.
  localparam logic [9:0] DRAW_TBL [0:7] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF,
                                            10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

  wire [6:0] ld   = {lp1, ld1, lp2, ld2, lp3, ld3, clr};
  wire [6:0] ld_s = {s_lp1, s_ld1, s_lp2, s_ld2, s_lp3, s_ld3, s_clr};

  baccarat_dealer_ctrl #(.CNT_W(8)) u_dut (
    .clk(clk), .resetb(resetb), .step(step),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .clr_cards(clr), .done(done),
    .player_win(pw), .dealer_win(dw), .tie(tw),
    .hands(hands), .pwins(pwins), .dwins(dwins), .ties(ties)
  );

  baccarat_dealer_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .resetb(resetb), .step(step),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(s_lp1), .load_pcard2(s_lp2), .load_pcard3(s_lp3),
    .load_dcard1(s_ld1), .load_dcard2(s_ld2), .load_dcard3(s_ld3),
    .clr_cards(s_clr), .done(s_done),
    .player_win(s_pw), .dealer_win(s_dw), .tie(s_tw),
    .hands(s_hands), .pwins(s_pwins), .dwins(s_dwins), .ties(s_ties)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic int card_val(input int code);
    return (code >= 1 && code <= 9) ? code : 0;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_hands"}, hands, sat(hm, 8));
    chk({tag, "_pwins"}, pwins, sat(pm, 8));
    chk({tag, "_dwins"}, dwins, sat(dm, 8));
    chk({tag, "_ties"},  ties,  sat(tm, 8));
    chk({tag, "_s_hands"}, s_hands, sat(hm, 2));
    chk({tag, "_s_pwins"}, s_pwins, sat(pm, 2));
    chk({tag, "_s_dwins"}, s_dwins, sat(dm, 2));
    chk({tag, "_s_ties"},  s_ties,  sat(tm, 2));
  endtask

  // Optional idle cycles, then a step whose strobe must match exp.
  task automatic do_step(input string tag, input logic [6:0] exp);
    int idle;
    idle = $urandom_range(0, 1);
    repeat (idle) begin
      @(negedge clk); step = 1'b0; #1;
      chk({tag, "_idle"}, ld, L_NONE);
    end
    @(negedge clk); step = 1'b1; #1;
    chk(tag, ld, exp);
    chk({tag, "_s"}, ld_s, exp);
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  // Automatic state: a step here must produce nothing.
  task automatic auto_cyc(input string tag);
    @(negedge clk); step = 1'($urandom_range(0, 1)); #1;
    chk(tag, ld, L_NONE);
    chk({tag, "_done"}, done, 1'b0);
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic deal_four(input int p2, input int d2, input bit check_one);
    pcard3 = 4'd0;
    do_step("p1", L_P1);
    pscore = 4'($urandom_range(1, 9));
    if (check_one) begin
      @(negedge clk); step = 1'b0; #1;
      chk("p1_one_cycle", ld, L_NONE);
    end
    do_step("d1", L_D1);
    dscore = 4'($urandom_range(1, 9));
    do_step("p2", L_P2);
    pscore = 4'(p2);
    do_step("d2", L_D2);
    dscore = 4'(d2);
  endtask

  task automatic run_hand(input int p2, input int d2, input int pc3, input int dc3);
    bit natural, pdraw, bdraw;
    int pf, df;
    natural = (p2 >= 8) || (d2 >= 8);
    pdraw   = !natural && (p2 <= 5);
    pf      = pdraw ? (p2 + card_val(pc3)) % 10 : p2;
    bdraw   = !natural && (pdraw ? DRAW_TBL[d2][card_val(pc3)] : (d2 <= 5));
    df      = bdraw ? (d2 + card_val(dc3)) % 10 : d2;

    deal_four(p2, d2, 1'b0);
    auto_cyc("eval1");
    if (pdraw) begin
      do_step("p3", L_P3);
      pcard3 = 4'(pc3);
      pscore = 4'(pf);
      auto_cyc("eval2");
    end
    if (bdraw) begin
      do_step("d3", L_D3);
      dscore = 4'(df);
    end
    auto_cyc("score");

    hm++;
    if (pf > df)      pm++;
    else if (df > pf) dm++;
    else              tm++;
    chk("done", done, 1'b1);
    chk("flags", {pw, dw, tw}, {pf > df, df > pf, pf == df});
    chk("flags_s", {s_pw, s_dw, s_tw}, {pf > df, df > pf, pf == df});
    chk_counts("hand");

    do_step("clr", L_CLR);
    chk("clr_flags", {pw, dw, tw}, 3'b000);
    chk("clr_done", done, 1'b0);
    chk_counts("clr");
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
  endtask

  initial begin
    resetb = 1'b0;
    step   = 1'b1;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    #1;
    chk("rst_load_pre", ld, L_NONE);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_load", ld, L_NONE);
      chk("rst_load_s", ld_s, L_NONE);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {pw, dw, tw}, 3'b000);
      chk_counts("rst");
    end
    @(negedge clk);
    resetb = 1'b1;
    step   = 1'b0;

    // First load strobe is a single cycle, then natural player win.
    deal_four(8, 3, 1'b1);
    auto_cyc("eval1_nat");
    auto_cyc("score_nat");
    hm++; pm++;
    chk("nat_done", done, 1'b1);
    chk("nat_flags", {pw, dw, tw}, 3'b100);
    chk_counts("nat");
    do_step("nat_clr", L_CLR);
    chk("nat_clr_flags", {pw, dw, tw}, 3'b000);
    chk_counts("nat_clr");

    run_hand(4, 3, 8, 5);   // banker stands on 3 vs an 8, dealer wins
    run_hand(4, 3, 12, 4);  // face card as third, banker draws
    run_hand(6, 5, 1, 1);   // player stands, banker draws to a tie
    run_hand(7, 7, 3, 3);   // both stand, tie
    run_hand(5, 6, 6, 2);   // banker 6 draws on a 6
    run_hand(5, 6, 5, 2);   // banker 6 stands on a 5
    run_hand(3, 9, 2, 2);   // banker natural

    repeat (40)
      run_hand($urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(1, 13), $urandom_range(1, 13));

    // Reset asserted while waiting in the player third-card state.
    deal_four(4, 3, 1'b0);
    auto_cyc("eval1_r");
    @(negedge clk); resetb = 1'b0; step = 1'b1; #1;
    chk("rst_p3_load", ld, L_NONE);
    chk("rst_p3_load_s", ld_s, L_NONE);
    @(posedge clk); #1;
    hm = 0; pm = 0; dm = 0; tm = 0;
    chk("rst_p3_done", done, 1'b0);
    chk("rst_p3_flags", {pw, dw, tw}, 3'b000);
    chk_counts("rst_p3");
    @(negedge clk); resetb = 1'b1; step = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;

    // Saturation of the 2-bit instance.
    repeat (5) run_hand(9, 0, 1, 1);
    chk("sat_hands", s_hands, 2'd3);
    chk("sat_pwins", s_pwins, 2'd3);
    chk("wide_hands", hands, 8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_dealer_ctrl.md
Name: baccarat_dealer_ctrl

Overview:
Sequencing controller for the baccarat card datapath. It issues the per-slot card load strobes in deal order and applies the player and banker third-card rules using the datapath's combinational scores and player third card. It latches the hand result and keeps saturating win/tie/hand statistics. It sits beside the datapath, shares its clock, and restarts hands on operator steps.

Parameters:
CNT_W, 8, width of each statistics counter (hands, pwins, dwins, ties)

Ports:
clk  input  1  clock; the datapath card registers use the same clock
resetb  input  1  synchronous active-low reset
step  input  1  one-cycle advance request (debounced operator key)
pscore  input  4  player hand total from datapath, 0-9, valid the cycle after a load
dscore  input  4  banker hand total from datapath, 0-9
pcard3  input  4  player third card code, 0=empty, 1-13 (A..K)
load_pcard1..load_pcard3  output  1 each  player card register enables
load_dcard1..load_dcard3  output  1 each  banker card register enables
clr_cards  output  1  one-cycle card clear; integration drives datapath reset as resetb & ~clr_cards
done  output  1  high while in S_DONE
player_win, dealer_win, tie  output  1 each  registered hand result
hands, pwins, dwins, ties  output  CNT_W each  saturating statistics

Behaviour:
- Reset: resetb is synchronous and active-low; clock is clk. With resetb=0 at a clk edge: state=S_P1, result flags=0, all counters=0. All load_* and clr_cards are forced 0 combinationally while resetb=0, including when step=1.
- States: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_SCORE, S_DONE.
- Deal states (S_P1, S_D1, S_P2, S_D2, S_P3, S_D3):
  - The matching load_* = step & (state==X). The output is Mealy and lasts exactly one cycle.
  - The state advances on the same edge: P1->D1->P2->D2->EVAL1, P3->EVAL2, D3->SCORE.
  - If step=0, hold the state; no load.
- S_EVAL1, S_EVAL2, S_SCORE: automatic one-cycle states; step is ignored. They sample the scores one cycle after the last load, so the datapath totals are settled.
- S_EVAL1 branches, in priority order:
  - pscore>=8 or dscore>=8 (natural) -> S_SCORE.
  - pscore<=5 -> S_P3.
  - Otherwise (player 6/7): dscore<=5 -> S_D3, else -> S_SCORE.
- S_EVAL2 banker rule:
  - v = third-card value: pcard3 for codes 1-9, 0 for codes 10-13.
  - Draw (-> S_D3) when any of:
    - dscore<=2;
    - dscore==3 and v!=8;
    - dscore==4 and v in 2..7;
    - dscore==5 and v in 4..7;
    - dscore==6 and v in 6..7.
  - dscore==7 stands. Not drawing -> S_SCORE.
- S_SCORE -> S_DONE, registering exactly one flag:
  - player_win = pscore>dscore;
  - dealer_win = dscore>pscore;
  - tie = equal.
  - On the same edge: hands+1, plus pwins, dwins or ties +1 to match the flag.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- S_DONE:
  - Holds the flags; done=1.
  - On step: clr_cards=1 for that cycle, flags cleared, -> S_P1.
  - Counters persist across hands and are cleared only by resetb.
- Exactly one output among load_* and clr_cards may be high in any cycle.
- A hand takes 4-6 step-triggered loads plus 2-3 automatic cycles.

Test Plan:
1. Reset with step held 1 for 2 cycles -> no load_*, done=0, flags and counters 0. Release reset, pulse step -> load_pcard1=1 for exactly 1 cycle, state S_D1.
2. 4 steps, bench model gives pscore=8, dscore=3 -> no load_pcard3 or load_dcard3. done=1 two cycles after the D2 step; player_win=1, hands=1, pwins=1.
3. pscore=4, dscore=3 -> step loads pcard3. Sub-case pcard3=8: banker stands; pscore=2 vs dscore=3 -> dealer_win=1. Sub-case pcard3=12 (v=0): load_dcard3 issued on the next step.
4. pscore=6, dscore=5 -> S_D3 directly, load_pcard3 never asserted. Next step -> load_dcard3; final pscore=6, dscore=6 -> tie=1, ties=1.
5. In S_DONE, step -> clr_cards for 1 cycle, flags 0, counters unchanged. The next step gives load_pcard1.
6. Reset asserted in S_P3 with step=1 -> no load_pcard3, state S_P1, counters 0. With CNT_W=2 and 5 player-win hands -> hands=3, pwins=3, with no wrap.
